// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one external combinational ALU: registered issue stage, registered results.
// Define ALU_ARB_RR_EN for round-robin arbitration instead of fixed priority with a starvation guard.
module alu_share_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_ctrl,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_ctrl,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic            flush0,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_y,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_y,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_y
);

  logic            req0_eff;
  logic            grant0;
  logic            grant1;

  logic            iss_vld_q,  iss_vld_d;
  logic            iss_own_q,  iss_own_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [XLEN-1:0] alu_a_q,    alu_a_d;
  logic [XLEN-1:0] alu_b_q,    alu_b_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [XLEN-1:0] rsp0_y_q,   rsp0_y_d;
  logic [XLEN-1:0] rsp1_y_q,   rsp1_y_d;

  // A flushed port-0 request never competes, so port 1 can use the slot.
  assign req0_eff = req0_valid && !flush0;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    last_d = last_q;
    if (req0_eff && req1_valid) begin
      grant0 = last_q;
      grant1 = !last_q;
      last_d = !last_q;
    end else begin
      grant0 = req0_eff;
      grant1 = req1_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  typedef enum logic [0:0] {PRIO0, FORCE1} state_e;
  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic            starved;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == FORCE1) begin
      grant1 = req1_valid;
      grant0 = req0_eff && !req1_valid;
    end else begin
      grant0 = req0_eff;
      grant1 = req1_valid && !req0_eff;
    end

    starved      = req1_valid && !grant1;
    starve_cnt_d = '0;
    if (starved)
      starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;

    state_d = state_q;
    case (state_q)
      PRIO0:   if (starved && starve_cnt_q == CNT_MAX) state_d = FORCE1;
      FORCE1:  if (grant1 || !req1_valid)              state_d = PRIO0;
      default: state_d = PRIO0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PRIO0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Operand registers hold across idle cycles; only the valid bit drops.
  always_comb begin
    iss_vld_d  = grant0 || grant1;
    iss_own_d  = grant1;
    alu_ctrl_d = alu_ctrl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    if (grant0) begin
      alu_ctrl_d = req0_ctrl;
      alu_a_d    = req0_a;
      alu_b_d    = req0_b;
    end else if (grant1) begin
      alu_ctrl_d = req1_ctrl;
      alu_a_d    = req1_a;
      alu_b_d    = req1_b;
    end

    rsp0_valid_d = iss_vld_q && !iss_own_q && !flush0;
    rsp1_valid_d = iss_vld_q && iss_own_q;
    rsp0_y_d     = rsp0_valid_d ? alu_y : rsp0_y_q;
    rsp1_y_d     = rsp1_valid_d ? alu_y : rsp1_y_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld_q    <= 1'b0;
      iss_own_q    <= 1'b0;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_y_q     <= '0;
      rsp1_y_q     <= '0;
    end else begin
      iss_vld_q    <= iss_vld_d;
      iss_own_q    <= iss_own_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_y_q     <= rsp0_y_d;
      rsp1_y_q     <= rsp1_y_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_y     = rsp0_y_q;
  assign rsp1_y     = rsp1_y_q;

endmodule
